// File: rtl/down_counter_if.sv
// -----------------------------------------------------------------------------
// down_counter_if
// Control and status bundle of the loadable down-counter.
//
//   start_i  : load value_i and begin counting
//   value_i  : start/reload value, sampled only when start_i is accepted
//   reload_i : mode sampled with start_i (1 = periodic, 0 = one-shot)
//   stop_i   : abort counting
//   ena_i    : count enable; low pauses prescaler and count
//   count_o  : current count value
//   busy_o   : high while counting
//   last_o   : one-cycle pulse on the step to zero (or a zero load)
//
// The master modport belongs to whoever commands the counter; the slave
// modport is the counter itself.
// -----------------------------------------------------------------------------
interface down_counter_if #(
   parameter int WIDTH = 8
);
   logic             start_i;
   logic [WIDTH-1:0] value_i;
   logic             reload_i;
   logic             stop_i;
   logic             ena_i;
   logic [WIDTH-1:0] count_o;
   logic             busy_o;
   logic             last_o;

   modport master (
      output start_i, value_i, reload_i, stop_i, ena_i,
      input  count_o, busy_o, last_o
   );

   modport slave (
      input  start_i, value_i, reload_i, stop_i, ena_i,
      output count_o, busy_o, last_o
   );
endinterface

// File: rtl/down_counter.sv
// -----------------------------------------------------------------------------
// down_counter
// Loadable down-counter / timer. A start command loads a value, the count then
// steps down once every PRESCALE enabled cycles. The step to zero raises
// last_o for one cycle; the counter then either stops (one-shot) or reloads
// the start value on the following step (periodic, period = V+1 steps).
//
// Ports:
//   clk_i : clock, rising edge
//   rst_i : synchronous reset, active-high
//   bus   : down_counter_if slave modport (start/value/reload/stop/ena in,
//           count/busy/last out)
//
// Parameters:
//   WIDTH    : count and load value width (>= 1); must match bus WIDTH
//   PRESCALE : enabled clock cycles per count step (>= 1)
// -----------------------------------------------------------------------------
module down_counter #(
   parameter int WIDTH    = 8,
   parameter int PRESCALE = 1
) (
   input  logic           clk_i,
   input  logic           rst_i,
   down_counter_if.slave  bus
);

   localparam int               PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
   localparam logic [PS_W-1:0]  PS_ONE  = PS_W'(1);
   localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state_q,  state_d;
   logic [WIDTH-1:0] count_q,  count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic [PS_W-1:0]  pre_q,    pre_d;
   logic             mode_q,   mode_d;
   logic             last_q,   last_d;

   // Next-state logic. Priority: stop > start > count step (reset is applied
   // in the register process).
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      pre_d    = pre_q;
      mode_d   = mode_q;
      last_d   = 1'b0;

      if (bus.stop_i) begin
         // Abort keeps the visible count; in IDLE there is nothing to abort.
         if (state_q == RUN) begin
            state_d = IDLE;
            pre_d   = '0;
         end
      end else if (bus.start_i) begin
         // Accepted in either state; a restart discards any partial prescale.
         pre_d = '0;
         if (bus.value_i == '0) begin
            count_d = '0;
            last_d  = 1'b1;
            state_d = IDLE;
         end else begin
            count_d  = bus.value_i;
            reload_d = bus.value_i;
            mode_d   = bus.reload_i;
            state_d  = RUN;
         end
      end else if (state_q == RUN && bus.ena_i) begin
         if (pre_q == PS_LAST) begin
            pre_d = '0;
            if (count_q > CNT_ONE) begin
               count_d = count_q - CNT_ONE;
            end else if (count_q == CNT_ONE) begin
               count_d = '0;
               last_d  = 1'b1;
               // One-shot leaves RUN on the same edge that shows zero.
               if (!mode_q) begin
                  state_d = IDLE;
               end
            end else begin
               // Zero is only held in RUN by periodic mode: reload, no pulse.
               count_d = reload_q;
            end
         end else begin
            pre_d = pre_q + PS_ONE;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      if (rst_i) begin
         state_q  <= IDLE;
         count_q  <= '0;
         reload_q <= '0;
         pre_q    <= '0;
         mode_q   <= 1'b0;
         last_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         pre_q    <= pre_d;
         mode_q   <= mode_d;
         last_q   <= last_d;
      end
   end

   assign bus.count_o = count_q;
   assign bus.busy_o  = (state_q == RUN);
   assign bus.last_o  = last_q;

endmodule

// File: tb/tb_down_counter.sv
// -----------------------------------------------------------------------------
// tb_down_counter
// Three counters share one command stream: W8/P1, W8/P4 and W4/P1. A
// step-level reference model predicts every counter after every edge;
// directed scenarios add fixed expected sequences, then random commands run.
// -----------------------------------------------------------------------------
module tb_down_counter;

   localparam int NI = 3;
   localparam int W_[NI] = '{8, 8, 4};
   localparam int P_[NI] = '{1, 4, 1};

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       start, stop, ena, reload;
   logic [7:0] value;

   int n_checks = 0;
   int n_fail   = 0;

   down_counter_if #(.WIDTH(8)) if0 ();
   down_counter_if #(.WIDTH(8)) if1 ();
   down_counter_if #(.WIDTH(4)) if2 ();

   assign if0.start_i = start;  assign if0.stop_i = stop;  assign if0.ena_i = ena;
   assign if0.reload_i = reload; assign if0.value_i = value;
   assign if1.start_i = start;  assign if1.stop_i = stop;  assign if1.ena_i = ena;
   assign if1.reload_i = reload; assign if1.value_i = value;
   assign if2.start_i = start;  assign if2.stop_i = stop;  assign if2.ena_i = ena;
   assign if2.reload_i = reload; assign if2.value_i = value[3:0];

   down_counter #(.WIDTH(8), .PRESCALE(1)) u0 (.clk_i(clk_i), .rst_i(rst_i), .bus(if0.slave));
   down_counter #(.WIDTH(8), .PRESCALE(4)) u1 (.clk_i(clk_i), .rst_i(rst_i), .bus(if1.slave));
   down_counter #(.WIDTH(4), .PRESCALE(1)) u2 (.clk_i(clk_i), .rst_i(rst_i), .bus(if2.slave));

   logic [7:0] obs_count [NI];
   logic       obs_busy  [NI];
   logic       obs_last  [NI];

   assign obs_count[0] = if0.count_o;
   assign obs_count[1] = if1.count_o;
   assign obs_count[2] = {4'b0000, if2.count_o};
   assign obs_busy[0]  = if0.busy_o;
   assign obs_busy[1]  = if1.busy_o;
   assign obs_busy[2]  = if2.busy_o;
   assign obs_last[0]  = if0.last_o;
   assign obs_last[1]  = if1.last_o;
   assign obs_last[2]  = if2.last_o;

   always #5 clk_i = ~clk_i;

   // Reference model state, one slot per counter.
   int m_count [NI];
   int m_pre   [NI];
   int m_rel   [NI];
   bit m_busy  [NI];
   bit m_last  [NI];
   bit m_mode  [NI];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Applies one clock edge's worth of commands to the model.
   task automatic model_edge();
      for (int i = 0; i < NI; i++) begin
         int v;
         v = int'(value) % (1 << W_[i]);
         if (rst_i) begin
            m_count[i] = 0; m_pre[i] = 0; m_rel[i] = 0;
            m_busy[i] = 0;  m_last[i] = 0; m_mode[i] = 0;
         end else begin
            m_last[i] = 0;
            if (stop) begin
               if (m_busy[i]) begin
                  m_busy[i] = 0;
                  m_pre[i]  = 0;
               end
            end else if (start) begin
               m_pre[i] = 0;
               if (v == 0) begin
                  m_count[i] = 0;
                  m_last[i]  = 1;
                  m_busy[i]  = 0;
               end else begin
                  m_count[i] = v;
                  m_rel[i]   = v;
                  m_mode[i]  = reload;
                  m_busy[i]  = 1;
               end
            end else if (m_busy[i] && ena) begin
               m_pre[i]++;
               if (m_pre[i] == P_[i]) begin
                  m_pre[i] = 0;
                  if (m_count[i] == 0) begin
                     m_count[i] = m_rel[i];
                  end else begin
                     m_count[i]--;
                     if (m_count[i] == 0) begin
                        m_last[i] = 1;
                        if (!m_mode[i]) m_busy[i] = 0;
                     end
                  end
               end
            end
         end
      end
   endtask

   task automatic compare_all();
      for (int i = 0; i < NI; i++) begin
         check($sformatf("u%0d_count", i), 32'(obs_count[i]), 32'(m_count[i]));
         check($sformatf("u%0d_busy", i),  32'(obs_busy[i]),  32'(m_busy[i]));
         check($sformatf("u%0d_last", i),  32'(obs_last[i]),  32'(m_last[i]));
      end
   endtask

   // One clock: model follows the edge, outputs are sampled 1 time unit later.
   task automatic tick();
      @(posedge clk_i);
      model_edge();
      #1;
      compare_all();
   endtask

   // Periodic-with-pause table: ena for the edge, expected count, expected last.
   localparam int PER_N = 13;
   localparam int PER_ENA  [PER_N] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1};
   localparam int PER_CNT  [PER_N] = '{2, 1, 0, 2, 1, 1, 1, 1, 1, 0, 2, 1, 0};
   localparam int PER_LAST [PER_N] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1};

   initial begin
      int busy_cycles;
      int n;
      int first_dec;
      int r;

      rst_i = 1'b1; start = 1'b1; value = 8'd5; stop = 1'b0; ena = 1'b1; reload = 1'b0;

      // Reset dominates a pending start.
      repeat (2) begin
         tick();
         check("rst_count", 32'(if0.count_o), 0);
         check("rst_busy",  32'(if0.busy_o),  0);
         check("rst_last",  32'(if0.last_o),  0);
      end
      rst_i = 1'b0; start = 1'b0;
      tick();
      check("rst_after_count", 32'(if0.count_o), 0);
      check("rst_after_busy",  32'(if0.busy_o),  0);

      // One-shot, value 3.
      value = 8'd3; reload = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      check("os_load_count", 32'(if0.count_o), 3);
      check("os_load_busy",  32'(if0.busy_o),  1);
      busy_cycles = 1;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (if0.busy_o) busy_cycles++;
         check("os_count", 32'(if0.count_o), 32'(2 - k));
         check("os_last",  32'(if0.last_o),  (k == 2) ? 1 : 0);
      end
      check("os_busy_at_zero", 32'(if0.busy_o), 0);
      check("os_busy_cycles", 32'(busy_cycles), 3);
      tick();
      check("os_last_pulse_width", 32'(if0.last_o), 0);

      // Periodic value 2 with a 4-cycle pause.
      value = 8'd2; reload = 1'b1; start = 1'b1;
      for (int k = 0; k < PER_N; k++) begin
         ena = PER_ENA[k][0];
         tick();
         start = 1'b0;
         check("per_count", 32'(if0.count_o), 32'(PER_CNT[k]));
         check("per_last",  32'(if0.last_o),  32'(PER_LAST[k]));
      end
      ena = 1'b1; stop = 1'b1;
      tick();
      stop = 1'b0;

      // Prescale 4: last_o 8 cycles after load.
      value = 8'd2; reload = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      check("ps_load_count", 32'(if1.count_o), 2);
      n = 0; first_dec = 0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (first_dec == 0 && if1.count_o == 8'd1) first_dec = k;
         if (if1.last_o) begin
            n = k;
            break;
         end
      end
      check("ps_first_step", 32'(first_dec), 4);
      check("ps_last_delay", 32'(n), 8);

      // Prescale 4 with ena low for 2 cycles after 3 enabled cycles.
      start = 1'b1;
      tick();
      start = 1'b0;
      first_dec = 0;
      for (int k = 1; k <= 20; k++) begin
         ena = (k == 4 || k == 5) ? 1'b0 : 1'b1;
         tick();
         if (if1.count_o == 8'd1) begin
            first_dec = k;
            break;
         end
      end
      ena = 1'b1;
      check("ps_pause_step", 32'(first_dec), 6);
      stop = 1'b1;
      tick();
      stop = 1'b0;

      // Precedence: stop beats start in RUN, then a zero load.
      value = 8'd9; reload = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      check("prec_count_before", 32'(if0.count_o), 5);
      stop = 1'b1; start = 1'b1; value = 8'd7;
      tick();
      check("prec_stop_count", 32'(if0.count_o), 5);
      check("prec_stop_busy",  32'(if0.busy_o),  0);
      check("prec_stop_last",  32'(if0.last_o),  0);
      stop = 1'b0; value = 8'd0;
      tick();
      start = 1'b0;
      check("zero_load_last",  32'(if0.last_o),  1);
      check("zero_load_busy",  32'(if0.busy_o),  0);
      check("zero_load_count", 32'(if0.count_o), 0);
      tick();
      check("zero_load_pulse", 32'(if0.last_o), 0);
      check("zero_load_idle",  32'(if0.busy_o), 0);

      // WIDTH=4 restart at full scale, then reset mid-count.
      value = 8'd15; reload = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      check("w4_load_max", 32'(if2.count_o), 15);
      repeat (3) tick();
      check("w4_after3", 32'(if2.count_o), 12);
      value = 8'd1; start = 1'b1;
      tick();
      start = 1'b0;
      check("w4_restart_count", 32'(if2.count_o), 1);
      tick();
      check("w4_restart_zero", 32'(if2.count_o), 0);
      check("w4_restart_last", 32'(if2.last_o),  1);
      tick();
      check("w4_restart_single", 32'(if2.last_o), 0);
      value = 8'd15; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (8) tick();
      check("w4_mid_count", 32'(if2.count_o), 7);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      check("w4_rst_count", 32'(if2.count_o), 0);
      check("w4_rst_last",  32'(if2.last_o),  0);
      check("w4_rst_busy",  32'(if2.busy_o),  0);

      // Random command stream against the model.
      for (int k = 0; k < 3000; k++) begin
         rst_i  = ($urandom_range(99) == 0);
         start  = ($urandom_range(11) == 0);
         stop   = start ? 1'b0 : ($urandom_range(24) == 0);
         ena    = ($urandom_range(3) != 0);
         reload = $urandom_range(1) != 0;
         r = int'($urandom_range(7));
         case (r)
            0:       value = 8'd0;
            1:       value = 8'd1;
            2:       value = 8'd255;
            3:       value = 8'($urandom_range(1, 4));
            default: value = 8'($urandom_range(255));
         endcase
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, n_checks=%0d", n_checks);
      $fatal(1, "time limit");
   end

endmodule
